// File: rtl/class_select_ctrl.sv
// Streaming argmax over NUM_CLASSES signed scores, valid/ready in and out.
// Define CLASS_SELECT_SCORE_OUT_EN to expose the winning score on max_score.
module class_select_ctrl #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     score_valid,
  input  logic signed [DATA_W-1:0] score_data,
  input  logic                     score_last,
  output logic                     score_ready,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [IDX_W-1:0]         class_idx,
  output logic                     busy,
  output logic                     len_err
`ifdef CLASS_SELECT_SCORE_OUT_EN
  ,
  output logic signed [DATA_W-1:0] max_score
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_best_idx;
  logic signed [DATA_W-1:0]  r_best;
  logic                      r_len_err;

  logic w_arm;
  logic w_beat;
  logic w_first;
  logic w_final;
  logic w_take;

  // A new scan arms from IDLE, or from DONE only together with the handshake.
  assign w_arm = start &&
                 ((r_state == S_IDLE) ||
                  (r_state == S_DONE && result_ready));

  assign w_beat  = (r_state == S_SCAN) && score_valid;
  assign w_first = (r_cnt == '0);
  assign w_final = (r_cnt == IDX_W'(NUM_CLASSES - 1));
  // Ties go to the later class; beat 0 always seeds the running max.
  assign w_take  = w_first || (score_data >= r_best);

  // Scan sequencer, running max and length check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_len_err  <= 1'b0;
    end else if (w_arm) begin
      r_state    <= S_SCAN;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_len_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_SCAN: begin
          if (w_beat) begin
            r_cnt <= r_cnt + IDX_W'(1);
            if (w_take) begin
              r_best     <= score_data;
              r_best_idx <= r_cnt;
            end
            if (score_last != w_final)
              r_len_err <= 1'b1;
            if (w_final)
              r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score_ready  = (r_state == S_SCAN);
  assign result_valid = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign class_idx    = r_best_idx;
  assign len_err      = r_len_err;
`ifdef CLASS_SELECT_SCORE_OUT_EN
  assign max_score    = r_best;
`endif

endmodule

// File: doc/class_select_ctrl.md
# class_select_ctrl

Sequencing controller for the output-layer classification stage.
- Arms on a `start` pulse and accepts `NUM_CLASSES` signed class scores one per beat over a valid/ready stream.
- Keeps a running maximum and its class index, using the same tie rule as the existing two-class argmax stage.
- Presents the winning index on a valid/ready result port, holding it until the downstream consumer takes it.
- Sits between the final dense layer's score buffer and the result/display logic. It replaces the fixed two-input compare when the network has more than two classes.

## Interface
Parameters:
- `NUM_CLASSES`, default 10: number of scores per inference; legal range 2..256.
- `DATA_W`, default 16: signed score width.
- `IDX_W`, default `$clog2(NUM_CLASSES)`: class index and beat counter width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle arm pulse; honoured only in IDLE, or in DONE in the same cycle as the result handshake.
- `score_valid`  in  1  a score beat is presented.
- `score_data`  in  `DATA_W`  signed class score; beat k is the score for class k.
- `score_last`  in  1  asserted by the source on beat `NUM_CLASSES-1`; used only for checking.
- `score_ready`  out  1  high only in SCAN.
- `result_valid`  out  1  high only in DONE.
- `result_ready`  in  1  downstream accepts the result.
- `class_idx`  out  `IDX_W`  winning class index; stable while `result_valid` is high.
- `busy`  out  1  high in SCAN or DONE.
- `len_err`  out  1  sticky flag for a `score_last` mismatch; cleared when a scan is armed.
- `max_score`  out  `DATA_W`  winning score; present only with `CLASS_SELECT_SCORE_OUT_EN`.

## Operation
FSM states:
- IDLE: waits for `start`. On `start`, clear the beat counter, `len_err` and the best-so-far registers, then go to SCAN.
- SCAN: `score_ready` = 1. A beat is accepted when `score_valid && score_ready`. On an accepted beat at count k:
  - k == 0: `best` <= `score_data`, `best_idx` <= 0, unconditionally.
  - k > 0: replace when `score_data >= best` (signed compare). Ties therefore resolve to the higher index, matching the two-class rule "class 0 only if strictly greater".
  - Length check: set `len_err` if `score_last` != (k == `NUM_CLASSES-1`).
  - Counter: increment on every accepted beat. After beat `NUM_CLASSES-1` is accepted, go to DONE. The scan length is set by the counter only; `score_last` never ends or extends a scan.
- DONE: `result_valid` = 1 and `class_idx` = `best_idx`.
  - On `result_ready`, go to IDLE.
  - If `start` is also high in that cycle, go directly to SCAN and re-arm as above.

Other rules:
- `start` in SCAN is ignored. `start` in DONE without `result_ready` is ignored and not remembered.
- `score_valid` outside SCAN is ignored; `score_ready` stays 0 there.
- Arithmetic is a plain signed `DATA_W` compare with no saturation or extension. The most negative value, 0x8000 for 16 bits, is a legal score.

## Timing
- Reset values (asynchronous on `reset_n` low): state = IDLE; `score_ready`, `result_valid`, `busy` and `len_err` = 0; `class_idx` = 0; `max_score` = 0; counter = 0.
- Reset during SCAN or DONE discards the partial result. No `result_valid` follows.
- `start` sampled in cycle 0 gives `score_ready` = 1 in cycle 1.
- With `score_valid` held high, beats are accepted in cycles 1..N and `result_valid` rises in cycle N+1 (N = `NUM_CLASSES`). Latency from the last accepted beat to `result_valid` is exactly 1 cycle.
- Back-to-back operation: a `start` in the same cycle as the DONE handshake gives `score_ready` = 1 in the next cycle. Sustained throughput is N+1 cycles per inference.
- `score_valid` gaps stall the scan indefinitely with no state change.
- Outputs are registered, with no combinational path from any input to any output.
- `score_ready` and `result_valid` are decodes of the registered state.

## Configuration
- `CLASS_SELECT_SCORE_OUT_EN` defined: adds the `max_score` output port.
  - Registered and equal to `best`.
  - Valid and stable while `result_valid` is high.
  - Reset value 0.
- `CLASS_SELECT_SCORE_OUT_EN` not defined: the port is absent and the `best` register is used internally only. Behaviour of all other ports is identical.

## Test plan
- Basic scan, `NUM_CLASSES` = 10, with scores -5,3,7,1,0,-2,6,2,4,-1 and `score_last` on beat 9:
  - `result_valid` exactly 1 cycle after beat 9.
  - `class_idx` = 2; `max_score` = 7 when the macro is enabled.
  - `len_err` = 0.
- Ties and extremes, scores all equal to 0x8000:
  - `class_idx` = 9, because the highest index wins on ties.
  - A second run with 0x7FFF at class 0 and 0x7FFE at every other class gives `class_idx` = 0.
- Backpressure and stalls:
  - Random `score_valid` gaps yield the same results as the basic scan.
  - Hold `result_ready` = 0 for 20 cycles: `result_valid` and `class_idx` stay stable.
  - `start` pulses during SCAN or DONE are ignored.
- Back-to-back inferences: assert `start` and `result_ready` together in DONE.
  - `score_ready` = 1 in the next cycle.
  - The second result is independent of the first; no carry-over of `best`.
- Length check:
  - `score_last` on beat 4 sets `len_err` = 1, and the scan still completes after 10 beats.
  - `len_err` clears on the next `start`.
  - `score_last` missing on beat 9 also sets `len_err`.
- Reset mid-operation: pull `reset_n` low after beat 5.
  - All outputs return to reset values immediately.
  - No `result_valid` appears.
  - The next full scan produces the correct index.
